// File: rtl/palette_loader_if.sv
// palette_loader_if: byte-source, palette-RAM write and status signals of the palette loader.
//   start, in_valid, in_data[7:0], vblank   core/video -> loader
//   in_ready                                loader -> byte source
//   load_color, load_color_index[5:0], load_color_data[23:0]   loader -> palette RAM
//   busy, done, overflow                    loader status
interface palette_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        vblank;
  logic        load_color;
  logic [5:0]  load_color_index;
  logic [23:0] load_color_data;
  logic        busy;
  logic        done;
  logic        overflow;
  modport master (output start, in_valid, in_data, vblank,
                  input in_ready, load_color, load_color_index, load_color_data, busy, done, overflow);
  modport slave (input start, in_valid, in_data, vblank,
                 output in_ready, load_color, load_color_index, load_color_data, busy, done, overflow);
endinterface

// File: rtl/palette_loader.sv
// palette_loader: assembles R,G,B bytes into 24-bit entries and writes them to the video palette RAM.
//   clk, reset (async active-high); bus = palette_loader_if.slave.
//   Define PAL_LOADER_VBLANK_GATE_EN to issue writes only while vblank=1.
module palette_loader #(
  parameter int ENTRIES    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  palette_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t      state, state_n;
  logic [23:0] mem [FIFO_DEPTH];
  logic [AW:0] rp, wp;
  logic [1:0]  bc;
  logic [7:0]  r, g;
  logic [6:0]  pc;
  logic [5:0]  wi;
  logic        ovf, lc;
  logic [5:0]  lci;
  logic [23:0] lcd;
  logic        win, empty, full, active, accept, push, pop, last;
`ifdef PAL_LOADER_VBLANK_GATE_EN
  assign win = bus.vblank;
`else
  logic unused_vblank;
  assign unused_vblank = bus.vblank;
  assign win = 1'b1;
`endif
  assign empty  = rp == wp;
  assign full   = (rp[AW] != wp[AW]) && (rp[AW-1:0] == wp[AW-1:0]);
  assign active = state == LOAD || state == DRAIN;
  assign accept = bus.in_valid && bus.in_ready && !bus.start;
  assign push   = accept && bc == 2'd2;
  // start suppresses any pop so no stale write follows a restart
  assign pop    = !empty && win && active && !bus.start;
  assign last   = push && pc == 7'(ENTRIES - 1);
  assign bus.in_ready         = state == LOAD && !full;
  assign bus.busy             = active;
  assign bus.done             = state == DONE;
  assign bus.overflow         = ovf;
  assign bus.load_color       = lc;
  assign bus.load_color_index = lci;
  assign bus.load_color_data  = lcd;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // DRAIN only sees an empty FIFO right after the final pop, so empty means the last write is out
  always_comb begin
    state_n = state;
    state_n = bus.start ? LOAD :
              state == LOAD ? (last ? DRAIN : LOAD) :
              state == DRAIN ? (empty ? DONE : DRAIN) : state;
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {r, g, bus.in_data};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rp <= '0;
      wp <= '0;
      bc <= '0;
      r <= '0;
      g <= '0;
      pc <= '0;
      wi <= '0;
      ovf <= 1'b0;
      lc <= 1'b0;
      lci <= '0;
      lcd <= '0;
    end else if (bus.start) begin
      rp <= '0;
      wp <= '0;
      bc <= '0;
      pc <= '0;
      wi <= '0;
      ovf <= 1'b0;
      lc <= 1'b0;
    end else begin
      if (accept) bc <= bc == 2'd2 ? 2'd0 : bc + 2'd1;
      if (accept && bc == 2'd0) r <= bus.in_data;
      if (accept && bc == 2'd1) g <= bus.in_data;
      if (push) begin
        wp <= wp + 1'b1;
        pc <= pc + 7'd1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
        wi <= wi + 6'd1;
        lci <= wi;
        lcd <= mem[rp[AW-1:0]];
      end
      lc <= pop;
      if (bus.in_valid && (state == DRAIN || state == DONE)) ovf <= 1'b1;
    end
endmodule
